param_readback: RTL
===================

// Module: param_readback
// PURPOSE
//  Read-back path for the debug parameter bus: the host requests one parameter register through
//  the in-system source word, and the block returns {status, seq, addr, data} on the probe word.
//  It is the responder-side complement of the parameter write control.
//  It sits between the source/probe debug instance and the parameter register bank.
//  Its register-bank handshake has variable latency.
// PARAMETERS
//  ADDR_W    8    register address width
//  DATA_W    16   register data width
//  NUM_REGS  4    implemented registers; addr >= NUM_REGS is an error
//  TIMEOUT   255  max WAIT cycles for rd_valid before error (>=1)
// PORTS
//  clk       in   1               system clock; source/probe run on this clock
//  reset     in   1               synchronous, active-high
//  cmd       in   ADDR_W+17       host word: [ADDR_W+16] req, [ADDR_W+15:16] addr, [15:0] unused
//  rd_en     out  1               one-cycle read strobe to the register bank
//  rd_addr   out  ADDR_W          read address, valid while rd_en=1
//  rd_data   in   DATA_W          read data, valid when rd_valid=1
//  rd_valid  in   1               read data valid (1 cycle)
//  probe     out  DATA_W+ADDR_W+6 {busy, err, seq[3:0], addr, data}, MSB first
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (reset).
//  - Reset values: rd_en=0, rd_addr=0, probe all 0, state IDLE, req_z=1.
//    Because req_z resets to 1, a req held high through reset does not trigger a read.
//  - Request detect: req_z <= req every cycle; start = req & ~req_z.
//  - States IDLE -> ISSUE -> WAIT -> DONE -> IDLE; bad address goes IDLE -> DONE.
//  - IDLE on start with addr < NUM_REGS:
//    latch addr; set probe.busy=1, probe.addr=addr; next ISSUE.
//  - IDLE on start with addr >= NUM_REGS:
//    latch addr; set err_next=1, data_next=0; next DONE; no rd_en is issued.
//  - ISSUE: rd_en=1 and rd_addr=addr for exactly 1 cycle; clear the timeout counter; next WAIT.
//  - WAIT: rd_valid is sampled here only (ignored in ISSUE, DONE and IDLE).
//    - rd_valid=1: capture rd_data, err_next=0; next DONE.
//    - Otherwise the counter increments. When it reaches TIMEOUT: err_next=1, data_next=0; next DONE.
//    - rd_valid in the same cycle the counter reaches TIMEOUT: the data wins, err=0.
//  - DONE, single cycle, updates probe:
//    data, err, addr; seq <= seq+1 (4-bit wrap, 15 -> 0); busy=0; next IDLE.
//  - Probe fields hold until the next DONE; only busy changes at start.
//  - Latency, good read, rd_valid k cycles after rd_en: start edge at cycle n.
//    rd_en is at n+1. The probe updates on the clock edge ending cycle n+2+k.
//  - A start in ISSUE/WAIT/DONE is dropped: no queue, no seq change.
//    The host polls seq/busy to detect completion.
//  - Reset mid-operation: return to IDLE with reset values; a later stray rd_valid is ignored.
//  - cmd[15:0] is ignored (write data belongs to the write path).
// STRUCTURE
//  - Shared include param_bus_defs.vh:
//    ADDR_W/DATA_W defaults, cmd bit positions (REQ_BIT, ADDR_LSB), probe field offsets,
//    state encodings ST_IDLE/ST_ISSUE/ST_WAIT/ST_DONE.
//  - Sub-module rise_edge_det (reset value selectable); also reusable by the write control.
//  - Timeout counter width $clog2(TIMEOUT+1); FSM and probe register in this module.
// TESTING
//  1 Reset with req=1, release, hold 20 cycles -> no rd_en, probe==0.
//  2 Bank answers 3 cycles after rd_en: req 0->1, addr=2, rd_data=16'hBEEF.
//    -> one rd_en with rd_addr=2; busy=1 after the edge.
//    -> probe={0,0,4'h1,8'h02,16'hBEEF}.
//  3 addr=8'h05 (NUM_REGS=4) -> no rd_en; probe err=1, data=0, addr=5, seq+1 within 2 cycles.
//  4 Bank never answers -> exactly TIMEOUT WAIT cycles, then err=1, data=0, busy=0.
//    A rd_valid arriving afterwards leaves the probe unchanged.
//  5 Second req edge while in WAIT -> ignored: one rd_en total, seq advances by 1.
//    Then 16 good reads -> seq wraps 15 -> 0.
//  6 Reset asserted in WAIT -> probe==0, IDLE; the following rd_valid pulse is ignored.
//    A new req then completes normally with seq=1.

Source files
------------

// File: rtl/param_readback_pkg.sv
// Shared definitions for the debug parameter bus read-back path:
// default widths, host word layout, probe layout and FSM state encoding.
package param_readback_pkg;

    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_NUM_REGS = 4;
    localparam int unsigned DEF_TIMEOUT  = 255;

    // Host word: req sits just above the address, cmd[15:0] carries write data only
    localparam int unsigned CMD_ADDR_LSB = 16;
    localparam int unsigned SEQ_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Probe word at default widths, MSB first
    typedef struct packed {
        logic                    busy;
        logic                    err;
        logic [SEQ_W-1:0]        seq;
        logic [DEF_ADDR_W-1:0]   addr;
        logic [DEF_DATA_W-1:0]   data;
    } probe_t;

endpackage

// File: rtl/param_readback_if.sv
// Register-bank read handshake: one-cycle strobe out, variable-latency data back.
interface param_readback_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
    modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/param_readback_edge.sv
// Rising-edge detector with selectable reset value for the delayed copy.
module rise_edge_det #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise_c
);
    logic d_z;

    always_ff @(posedge clk) begin
        if (reset) d_z <= RST_VAL;
        else       d_z <= d;
    end

    assign rise_c = d & ~d_z;
endmodule

// File: rtl/param_readback.sv
// Read-back responder: turns a host req edge into one register-bank read and
// publishes {busy, err, seq, addr, data} on the probe word.
module param_readback
    import param_readback_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W+16:0]         cmd,
    param_readback_if.master           bus,
    output logic [DATA_W+ADDR_W+5:0]   probe
);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned REQ_BIT = CMD_ADDR_LSB + ADDR_W;
    localparam logic [ADDR_W:0]  NUM_REGS_V = (ADDR_W+1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);

    logic              start_c;
    logic [ADDR_W-1:0] req_addr;
    logic              addr_ok_c;
    logic              unused_cmd;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_next_q;
    logic              err_next_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              busy_q;
    logic              err_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pdata_q;

    assign req_addr   = cmd[CMD_ADDR_LSB +: ADDR_W];
    assign addr_ok_c  = {1'b0, req_addr} < NUM_REGS_V;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign unused_cmd = &{1'b0, cmd[CMD_ADDR_LSB-1:0]};

    // Delayed req resets high so a req held through reset is not an edge
    rise_edge_det #(.RST_VAL(1'b1)) u_req_edge (
        .clk    (clk),
        .reset  (reset),
        .d      (cmd[REQ_BIT]),
        .rise_c (start_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_next_q <= '0;
            err_next_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            seq_q       <= '0;
            paddr_q     <= '0;
            pdata_q     <= '0;
        end else begin
            rd_en_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        addr_q <= req_addr;
                        if (addr_ok_c) begin
                            busy_q    <= 1'b1;
                            paddr_q   <= req_addr;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= req_addr;
                            state_q   <= ST_ISSUE;
                        end else begin
                            err_next_q  <= 1'b1;
                            data_next_q <= '0;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                // Data beats the timeout when both land on the same cycle
                ST_WAIT: begin
                    if (bus.rd_valid) begin
                        data_next_q <= bus.rd_data;
                        err_next_q  <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (cnt_inc == TIMEOUT_V) begin
                        cnt_q       <= cnt_inc;
                        err_next_q  <= 1'b1;
                        data_next_q <= '0;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_DONE: begin
                    pdata_q <= data_next_q;
                    err_q   <= err_next_q;
                    paddr_q <= addr_q;
                    seq_q   <= seq_q + SEQ_W'(1);
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign probe       = {busy_q, err_q, seq_q, paddr_q, pdata_q};
endmodule
